snd_cmd_latch: RTL and testbench

- Sound-board responder for the main-CPU sound strobe (active-low SNDSTB, asserted for main-CPU writes to the sound command address).
- Captures the command byte from the main data bus and holds it for the sound CPU.
- Raises an active-low interrupt to the sound CPU until the sound CPU reads the byte.
- Reports busy and overrun status; all logic runs on the sound-board clock, with SNDSTB and D asynchronous to it.

---
 rtl/snd_cmd_latch_if.sv | 12 +
 rtl/snd_cmd_latch.sv | 73 +++++++
 tb/tb_snd_cmd_latch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/snd_cmd_latch_if.sv
// snd_cmd_latch_if: main-board strobe/data and sound-CPU read/status bundle
interface snd_cmd_latch_if;
  logic       sndstb;
  logic [7:0] d;
  logic       srd;
  logic [7:0] dout;
  logic       sirq_n;
  logic       busy;
  logic       ovr;
  modport master (output sndstb, d, srd, input dout, sirq_n, busy, ovr);
  modport slave  (input sndstb, d, srd, output dout, sirq_n, busy, ovr);
endinterface

// File: rtl/snd_cmd_latch.sv
// snd_cmd_latch: synchronizes the main-CPU sound strobe, latches the command byte and interrupts the sound CPU
module snd_cmd_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 3,
  parameter bit OVERWRITE   = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  snd_cmd_latch_if.slave  bus
);
  typedef enum logic [1:0] {ARMED_WAIT, IDLE, LOW} state_t;
  localparam logic [3:0] MIN = 4'(MIN_LOW);
  logic [SYNC_STAGES-1:0] sync_q, vld_q;
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   s_stb, cap;
  assign s_stb = sync_q[SYNC_STAGES-1];
  // strobe synchronizer; vld_q marks when the chain holds real samples, so a strobe
  // already low at reset release is never mistaken for an idle-then-falling one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sndstb};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end
  // state register and low counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMED_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: count synchronized-low cycles in IDLE, one capture per strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARMED_WAIT: state_d = (vld_q[SYNC_STAGES-1] && s_stb) ? IDLE : ARMED_WAIT;
      IDLE: begin
        cnt_d   = s_stb ? 4'd0 : cnt_q + 4'd1;
        state_d = (!s_stb && cnt_d == MIN) ? LOW : IDLE;
      end
      LOW: begin
        cnt_d   = s_stb ? 4'd0 : cnt_q;
        state_d = s_stb ? IDLE : LOW;
      end
      default: state_d = ARMED_WAIT;
    endcase
  end
  // capture fires on the edge where the low count reaches MIN_LOW
  always_comb cap = (state_q == IDLE) && !s_stb && (cnt_q + 4'd1 == MIN);
  // command byte, status flags and registered interrupt; a read on the capture edge
  // consumes the old byte so the new one lands as if the latch were empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout   <= 8'h00;
      bus.busy   <= 1'b0;
      bus.ovr    <= 1'b0;
      bus.sirq_n <= 1'b1;
    end else begin
      bus.dout   <= (cap && (!bus.busy || bus.srd || OVERWRITE)) ? bus.d : bus.dout;
      bus.busy   <= cap | (bus.busy & ~bus.srd);
      bus.ovr    <= (bus.ovr & ~bus.srd) | (cap & bus.busy & ~bus.srd);
      bus.sirq_n <= ~bus.busy;
    end
  end
endmodule

// File: tb/tb_snd_cmd_latch.sv
// tb_snd_cmd_latch: random and directed strobes on overwrite and drop variants against a transaction model
module tb_snd_cmd_latch;
  localparam int S = 2;
  localparam int M = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sndstb = 1'b1;
  logic       srd = 1'b0;
  logic [7:0] d = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] m_dout [2];
  logic       m_busy [2];
  logic       m_ovr  [2];
  snd_cmd_latch_if i0();
  snd_cmd_latch_if i1();
  assign i0.sndstb = sndstb;
  assign i0.d      = d;
  assign i0.srd    = srd;
  assign i1.sndstb = sndstb;
  assign i1.d      = d;
  assign i1.srd    = srd;
  snd_cmd_latch #(.SYNC_STAGES(S), .MIN_LOW(M), .OVERWRITE(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  snd_cmd_latch #(.SYNC_STAGES(S), .MIN_LOW(M), .OVERWRITE(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, " u0.dout"},   i0.dout,          m_dout[0]);
    check({tag, " u0.busy"},   8'(i0.busy),      8'(m_busy[0]));
    check({tag, " u0.ovr"},    8'(i0.ovr),       8'(m_ovr[0]));
    check({tag, " u0.sirq_n"}, 8'(i0.sirq_n),    8'(!m_busy[0]));
    check({tag, " u1.dout"},   i1.dout,          m_dout[1]);
    check({tag, " u1.busy"},   8'(i1.busy),      8'(m_busy[1]));
    check({tag, " u1.ovr"},    8'(i1.ovr),       8'(m_ovr[1]));
    check({tag, " u1.sirq_n"}, 8'(i1.sirq_n),    8'(!m_busy[1]));
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = 8'h00;
      m_busy[k] = 1'b0;
      m_ovr[k]  = 1'b0;
    end
  endtask
  task automatic model_cap(input logic [7:0] v);
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k] || k == 0) m_dout[k] = v;
      if (m_busy[k]) m_ovr[k] = 1'b1;
      m_busy[k] = 1'b1;
    end
  endtask
  task automatic model_rd();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_ovr[k]  = 1'b0;
    end
  endtask
  task automatic strobe(input logic [7:0] v, input int len);
    @(negedge clk);
    d = v;
    sndstb = 1'b0;
    repeat (len) @(negedge clk);
    sndstb = 1'b1;
    repeat (S + 2) @(negedge clk);
    if (len >= M) model_cap(v);
  endtask
  task automatic rd();
    @(negedge clk);
    srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    @(negedge clk);
    model_rd();
  endtask
  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #10 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    strobe(8'h3C, 1);
    check_all("glitch1");
    strobe(8'h3C, M - 1);
    check_all("glitch2");
    @(negedge clk);
    d = 8'hA5;
    sndstb = 1'b0;
    repeat (S + M - 1) @(posedge clk);
    #1 check("lat_pre busy", 8'(i0.busy), 8'h00);
    @(posedge clk);
    #1 check("lat busy", 8'(i0.busy), 8'h01);
    check("lat dout", i0.dout, 8'hA5);
    check("lat sirq_hi", 8'(i0.sirq_n), 8'h01);
    @(posedge clk);
    #1 check("lat sirq_lo", 8'(i0.sirq_n), 8'h00);
    @(negedge clk);
    sndstb = 1'b1;
    repeat (S + 2) @(negedge clk);
    model_cap(8'hA5);
    check_all("basic");
    srd = 1'b1;
    @(posedge clk);
    #1 check("rd busy", 8'(i0.busy), 8'h00);
    check("rd sirq_still", 8'(i0.sirq_n), 8'h00);
    @(negedge clk);
    srd = 1'b0;
    @(posedge clk);
    #1 check("rd sirq", 8'(i0.sirq_n), 8'h01);
    check("rd dout", i0.dout, 8'hA5);
    model_rd();
    strobe(8'h11, 5);
    strobe(8'h22, 5);
    check_all("overrun");
    rd();
    check_all("overrun_rd");
    @(negedge clk);
    d = 8'h5A;
    sndstb = 1'b0;
    repeat (50) @(negedge clk);
    srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    repeat (148) @(negedge clk);
    sndstb = 1'b1;
    repeat (S + 2) @(negedge clk);
    model_cap(8'h5A);
    model_rd();
    check_all("long");
    strobe(8'h7E, 5);
    strobe(8'h01, 5);
    check_all("coll_pre");
    @(negedge clk);
    d = 8'h02;
    sndstb = 1'b0;
    for (int i = 0; i < S + M - 1; i++) begin
      @(negedge clk);
      check("coll sirq", 8'(i0.sirq_n | i1.sirq_n), 8'h00);
    end
    srd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      srd = 1'b0;
      check("coll sirq", 8'(i0.sirq_n | i1.sirq_n), 8'h00);
    end
    sndstb = 1'b1;
    repeat (S + 2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = 8'h02;
      m_busy[k] = 1'b1;
      m_ovr[k]  = 1'b0;
    end
    check_all("collision");
    rd();
    @(negedge clk);
    d = 8'h99;
    sndstb = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all("post_reset_low");
    sndstb = 1'b1;
    repeat (S + 2) @(negedge clk);
    strobe(8'h66, M);
    check_all("post_reset_cap");
    for (int n = 0; n < 40; n++) begin
      strobe(8'($urandom), int'($urandom_range(1, M + 3)));
      if ($urandom_range(0, 2) == 0) rd();
      check_all($sformatf("rand%0d", n));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
